// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle between the ID-stage decoder/pipeline control and hazard_ctrl.
//
// Decoder -> hazard unit (master drives, slave receives):
//   id_valid       ID holds a decoded instruction
//   id_rs1/id_rs2  ID source registers
//   id_rs1_used    ID instruction reads rs1
//   id_rs2_used    ID instruction reads rs2
//   id_rd          ID destination register
//   id_rf_we       ID instruction writes the register file
//   id_is_load     ID writeback select is DRAM read data
//   ex_redirect    branch taken / jump resolved in EX this cycle
// Hazard unit -> pipeline (slave drives, master receives):
//   stall_pc, stall_if_id, flush_if_id, flush_id_ex
//   fwd_sel1/fwd_sel2  operand source: 00 RF, 01 EX, 10 MEM, 11 WB
// ---------------------------------------------------------------------------
interface hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_rf_we;
  logic              id_is_load;
  logic              ex_redirect;
  logic              stall_pc;
  logic              stall_if_id;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic [1:0]        fwd_sel1;
  logic [1:0]        fwd_sel2;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rf_we, id_is_load, ex_redirect,
    input  stall_pc, stall_if_id, flush_if_id, flush_id_ex,
           fwd_sel1, fwd_sel2
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_rf_we, id_is_load, ex_redirect,
    output stall_pc, stall_if_id, flush_if_id, flush_id_ex,
           fwd_sel1, fwd_sel2
  );
endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Hazard scheduler for the 5-stage RV32 pipeline. Keeps a shadow scoreboard
// of the EX/MEM/WB destination registers and produces ID-stage forwarding
// selects, load-use stalls and branch/jump flushes.
//
// Ports:
//   clk    core clock
//   rst_n  synchronous active-low reset (outputs forced low while asserted)
//   bus    hazard_ctrl_if.slave (decoder inputs, stall/flush/forward outputs)
// Optional (macro HAZARD_CTRL_PERF_EN):
//   perf_stall_cnt  cycles with stall_pc asserted (wraps)
//   perf_flush_cnt  cycles with ex_redirect asserted (wraps)
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  hazard_ctrl_if.slave bus
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

  // Elaboration-time sanity check on the counter width.
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hazard_ctrl: CNT_W must be at least 1");
  end

  // Scoreboard entries: valid, destination register, produced-by-load.
  logic              ex_v,  mem_v,  wb_v;
  logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
  logic              ex_ld, mem_ld, wb_ld;

  logic rs1_ex, rs1_mem, rs1_wb;
  logic rs2_ex, rs2_mem, rs2_wb;
  logic load_use;
  logic bubble;

  // Match terms. x0 never hits because its entry is never marked valid.
  assign rs1_ex  = ex_v  & bus.id_rs1_used & (ex_rd  == bus.id_rs1);
  assign rs1_mem = mem_v & bus.id_rs1_used & (mem_rd == bus.id_rs1);
  assign rs1_wb  = wb_v  & bus.id_rs1_used & (wb_rd  == bus.id_rs1);
  assign rs2_ex  = ex_v  & bus.id_rs2_used & (ex_rd  == bus.id_rs2);
  assign rs2_mem = mem_v & bus.id_rs2_used & (mem_rd == bus.id_rs2);
  assign rs2_wb  = wb_v  & bus.id_rs2_used & (wb_rd  == bus.id_rs2);

  // A load in EX cannot forward yet; its consumer waits one cycle and then
  // picks the data up from MEM.
  assign load_use = bus.id_valid & ex_ld & (rs1_ex | rs2_ex);
  assign bubble   = load_use | bus.ex_redirect;

  // Stall/flush outputs. A redirect squashes the ID instruction, so it
  // overrides any load-use stall.
  always_comb begin
    bus.stall_pc    = 1'b0;
    bus.stall_if_id = 1'b0;
    bus.flush_if_id = 1'b0;
    bus.flush_id_ex = 1'b0;
    if (rst_n) begin
      bus.stall_pc    = load_use & ~bus.ex_redirect;
      bus.stall_if_id = load_use & ~bus.ex_redirect;
      bus.flush_if_id = bus.ex_redirect;
      bus.flush_id_ex = bubble;
    end
  end

  // Forwarding selects: youngest producer wins, each source independent.
  always_comb begin
    bus.fwd_sel1 = 2'b00;
    bus.fwd_sel2 = 2'b00;
    if (rst_n && bus.id_valid) begin
      if (rs1_ex)       bus.fwd_sel1 = 2'b01;
      else if (rs1_mem) bus.fwd_sel1 = 2'b10;
      else if (rs1_wb)  bus.fwd_sel1 = 2'b11;
      if (rs2_ex)       bus.fwd_sel2 = 2'b01;
      else if (rs2_mem) bus.fwd_sel2 = 2'b10;
      else if (rs2_wb)  bus.fwd_sel2 = 2'b11;
    end
  end

  // Scoreboard shift. The ID instruction enters EX unless a bubble is
  // inserted (load-use stall or redirect squash).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_v   <= 1'b0;
      ex_rd  <= '0;
      ex_ld  <= 1'b0;
      mem_v  <= 1'b0;
      mem_rd <= '0;
      mem_ld <= 1'b0;
      wb_v   <= 1'b0;
      wb_rd  <= '0;
      wb_ld  <= 1'b0;
    end else begin
      wb_v   <= mem_v;
      wb_rd  <= mem_rd;
      wb_ld  <= mem_ld;
      mem_v  <= ex_v;
      mem_rd <= ex_rd;
      mem_ld <= ex_ld;
      if (bubble) begin
        ex_v  <= 1'b0;
        ex_rd <= '0;
        ex_ld <= 1'b0;
      end else begin
        ex_v  <= bus.id_valid & bus.id_rf_we & (bus.id_rd != '0);
        ex_rd <= bus.id_rd;
        ex_ld <= bus.id_is_load;
      end
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  // Performance counters; both wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (bus.stall_pc)    perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      if (bus.ex_redirect) perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
    end
  end
`else
  // wb_ld is carried for completeness of the entry; nothing consumes it.
  logic unused_wb_ld;
  assign unused_wb_ld = wb_ld;
`endif

`ifdef HAZARD_CTRL_PERF_EN
  logic unused_wb_ld_p;
  assign unused_wb_ld_p = wb_ld;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl. Directed vectors push their expected
// outputs into a queue; a monitor on the falling edge pops and compares.
// Expected word layout: {stall_pc, stall_if_id, flush_if_id, flush_id_ex,
// fwd_sel1[1:0], fwd_sel2[1:0]}.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  typedef struct {
    string      name;
    logic [7:0] bits;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  exp_t exp_q[$];

  hazard_ctrl_if #(.REG_AW(5)) bus ();

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus)
`ifdef HAZARD_CTRL_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point shared by monitor and directed checks.
  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Monitor: outputs settle after the inputs change just past posedge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput(e.name,
                  64'({bus.stall_pc, bus.stall_if_id, bus.flush_if_id,
                       bus.flush_id_ex, bus.fwd_sel1, bus.fwd_sel2}),
                  64'(e.bits));
    end
  end

  // One cycle of ID-stage inputs plus the expected hazard outputs.
  task automatic applyStimulus(input string name, input logic rstn, input logic vld,
                               input logic [4:0] rs1, input logic rs1u,
                               input logic [4:0] rs2, input logic rs2u,
                               input logic [4:0] rd, input logic we, input logic ld,
                               input logic redir, input logic [7:0] exp_bits);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n           = rstn;
    bus.id_valid    = vld;
    bus.id_rs1      = rs1;
    bus.id_rs1_used = rs1u;
    bus.id_rs2      = rs2;
    bus.id_rs2_used = rs2u;
    bus.id_rd       = rd;
    bus.id_rf_we    = we;
    bus.id_is_load  = ld;
    bus.ex_redirect = redir;
    e.name = name;
    e.bits = exp_bits;
    exp_q.push_back(e);
  endtask

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    rst_n           = 1'b0;
    bus.id_valid    = 1'b0;
    bus.id_rs1      = '0;
    bus.id_rs1_used = 1'b0;
    bus.id_rs2      = '0;
    bus.id_rs2_used = 1'b0;
    bus.id_rd       = '0;
    bus.id_rf_we    = 1'b0;
    bus.id_is_load  = 1'b0;
    bus.ex_redirect = 1'b0;

    // Reset: outputs forced low even with a redirect and a writer in ID.
    applyStimulus("reset0", 0, 1, 5, 1, 0, 0, 5, 1, 0, 1, 8'b0000_00_00);
    applyStimulus("reset1", 0, 1, 5, 1, 0, 0, 5, 1, 0, 1, 8'b0000_00_00);
    applyStimulus("post_reset_empty", 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 8'b0000_00_00);

    // Forward chain on x5: EX, MEM, WB, then register file.
    applyStimulus("add_x5",   1, 1, 1, 1, 2, 1, 5, 1, 0, 0, 8'b0000_00_00);
    applyStimulus("fwd_ex",   1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 8'b0000_01_00);
    applyStimulus("fwd_mem",  1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 8'b0000_10_00);
    applyStimulus("fwd_wb",   1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 8'b0000_11_00);
    applyStimulus("fwd_rf",   1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 8'b0000_00_00);

    // Load-use on rs2: one stall cycle, then MEM forward.
    applyStimulus("load_x7",      1, 1, 2, 1, 0, 0, 7, 1, 1, 0, 8'b0000_00_00);
    applyStimulus("lu_stall",     1, 1, 1, 1, 7, 1, 8, 1, 0, 0, 8'b1101_00_01);
    applyStimulus("lu_after",     1, 1, 1, 1, 7, 1, 8, 1, 0, 0, 8'b0000_00_10);

    // x0 destinations and unused sources never match.
    applyStimulus("write_x0",     1, 1, 9, 1, 10, 1, 0, 1, 0, 0, 8'b0000_00_00);
    applyStimulus("x0_unused",    1, 1, 0, 1, 8, 0, 0, 0, 0, 0, 8'b0000_00_00);
    applyStimulus("load_x0",      1, 1, 3, 1, 4, 1, 0, 1, 1, 0, 8'b0000_00_00);
    applyStimulus("read_x0",      1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 8'b0000_00_00);

    // Redirect beats load-use; EX becomes a bubble afterwards.
    applyStimulus("load_x6",      1, 1, 1, 1, 0, 0, 6, 1, 1, 0, 8'b0000_00_00);
    applyStimulus("redir_lu",     1, 1, 6, 1, 6, 1, 9, 1, 0, 1, 8'b0011_01_01);
    applyStimulus("ex_bubble",    1, 1, 9, 1, 6, 1, 0, 0, 0, 0, 8'b0000_00_10);
    applyStimulus("invalid_id",   1, 0, 6, 1, 0, 0, 0, 0, 0, 0, 8'b0000_00_00);

    // Youngest producer wins; sources resolved independently.
    applyStimulus("w_x3_a",       1, 1, 3, 0, 0, 0, 3, 1, 0, 0, 8'b0000_00_00);
    applyStimulus("w_x4",         1, 1, 3, 0, 0, 0, 4, 1, 0, 0, 8'b0000_00_00);
    applyStimulus("w_x3_b",       1, 1, 3, 0, 0, 0, 3, 1, 0, 0, 8'b0000_00_00);
    applyStimulus("prio_ex_mem",  1, 1, 3, 1, 4, 1, 0, 0, 0, 0, 8'b0000_01_10);
    applyStimulus("prio_mem_wb",  1, 1, 3, 1, 4, 1, 0, 0, 0, 0, 8'b0000_10_11);

    // Back-to-back loads feeding dependents: one stall each.
    applyStimulus("load_x10",     1, 1, 0, 0, 0, 0, 10, 1, 1, 0, 8'b0000_00_00);
    applyStimulus("load_x11_stl", 1, 1, 10, 1, 0, 0, 11, 1, 1, 0, 8'b1101_01_00);
    applyStimulus("load_x11_go",  1, 1, 10, 1, 0, 0, 11, 1, 1, 0, 8'b0000_10_00);
    applyStimulus("add_stl",      1, 1, 11, 1, 10, 1, 12, 1, 0, 0, 8'b1101_01_11);
    applyStimulus("add_go",       1, 1, 11, 1, 10, 1, 12, 1, 0, 0, 8'b0000_10_00);

    // Plain redirect.
    applyStimulus("redir",        1, 1, 12, 1, 0, 0, 0, 0, 0, 1, 8'b0011_01_00);
    applyStimulus("load_x13",     1, 1, 12, 1, 0, 0, 13, 1, 1, 0, 8'b0000_10_00);
`ifdef HAZARD_CTRL_PERF_EN
    checkOutput("perf_stall", 64'(perf_stall_cnt), 64'd3);
    checkOutput("perf_flush", 64'(perf_flush_cnt), 64'd2);
`endif

    // Reset while a load-use hazard is pending.
    applyStimulus("rst_mid_stall", 0, 1, 13, 1, 0, 0, 0, 0, 0, 0, 8'b0000_00_00);
    applyStimulus("after_rst",     1, 1, 13, 1, 0, 0, 0, 0, 0, 0, 8'b0000_00_00);
    applyStimulus("idle",          1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_00_00);
`ifdef HAZARD_CTRL_PERF_EN
    checkOutput("perf_stall_clr", 64'(perf_stall_cnt), 64'd0);
    checkOutput("perf_flush_clr", 64'(perf_flush_cnt), 64'd0);
`endif

    // Drain the scoreboard queue with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard scheduler for the 5-stage RV32 core (IF/ID/EX/MEM/WB).
- Sits beside the ID-stage decoder and consumes its per-instruction register-usage, write-enable and writeback-select outputs.
- Keeps a registered shadow scoreboard of the EX/MEM/WB destination registers.
- Generates ID-stage forwarding selects, load-use stalls and branch/jump flushes.

Parameters:
- REG_AW, 5, register-file address width.
- CNT_W, 32, perf counter width (only used with the optional feature).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  ID holds a decoded instruction (decoder have_inst).
- id_rs1  in  REG_AW  ID source register 1.
- id_rs2  in  REG_AW  ID source register 2.
- id_rs1_used  in  1  ID instruction reads rs1.
- id_rs2_used  in  1  ID instruction reads rs2.
- id_rd  in  REG_AW  ID destination register.
- id_rf_we  in  1  ID instruction writes the RF.
- id_is_load  in  1  ID writeback select is DRAM read data.
- ex_redirect  in  1  branch taken or jump resolved in EX this cycle.
- stall_pc  out  1  hold the PC.
- stall_if_id  out  1  hold the IF/ID register.
- flush_if_id  out  1  clear IF/ID to a bubble.
- flush_id_ex  out  1  load a bubble into ID/EX.
- fwd_sel1  out  2  rs1 operand source: 00 RF, 01 EX result, 10 MEM result (incl. load data), 11 WB data.
- fwd_sel2  out  2  rs2 operand source, same encoding.

Behaviour:
- Scoreboard: three registered entries, EX, MEM and WB. Each holds {v, rd, ld}.
- Reset (rst_n low at posedge): all entries v=0, rd=0, ld=0.
- While rst_n is low, every output is forced low and fwd_sel1/fwd_sel2 are 00.
- Per-cycle advance (rst_n high): WB<=MEM, MEM<=EX.
- EX <= {id_valid & id_rf_we & (id_rd!=0), id_rd, id_is_load}, unless a bubble is inserted this cycle.
- On a bubble, EX <= {0, 0, 0}.
- Match rule: an entry matches a source when v=1, rd equals the source register, and the matching *_used bit is 1.
  - x0 never matches, because v is already 0 when rd=0.
- Forward priority per source: EX > MEM > WB > RF (youngest wins).
- fwd_sel outputs are combinational from the scoreboard plus the ID inputs.
- fwd_sel outputs are 00 when id_valid=0.
- Load-use: EX entry ld=1 and it matches rs1 or rs2 while id_valid=1.
  - Response: stall_pc=1, stall_if_id=1, flush_id_ex=1.
  - The scoreboard EX entry becomes a bubble.
  - Exactly 1 stall cycle. Next cycle the load sits in MEM and the operand is forwarded with sel=10.
- Redirect: ex_redirect=1 gives flush_if_id=1 and flush_id_ex=1, with stall_pc=0 and stall_if_id=0.
  - The scoreboard EX entry becomes a bubble.
  - 2 wrong-path instructions are squashed.
- Simultaneous redirect and load-use: redirect wins, no stall (the ID instruction is squashed anyway).
- Simultaneous matches (e.g. rs1 matches EX and rs2 matches WB) are resolved independently per source.
- If rs1==rs2, both selects are identical.
- Stall outputs never persist beyond 1 cycle per load-use event.
- Back-to-back loads feeding a dependent instruction still produce exactly 1 stall each.
- No internal FSM beyond the scoreboard pipeline.
- Reset mid-stall: the next cycle after reset shows an empty scoreboard and no stall.

Optional Feature:
- Macro: HAZARD_CTRL_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt[CNT_W-1:0] and perf_flush_cnt[CNT_W-1:0].
  - perf_stall_cnt increments once per cycle with stall_pc=1.
  - perf_flush_cnt increments once per cycle with ex_redirect=1.
  - Both wrap at 2^CNT_W and are cleared by rst_n.
- Undefined: neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset test: hold rst_n=0 for 2 cycles with id_valid=1 and id_rs1=5 -> all outputs 0 and fwd_sel1=00. After release, the scoreboard is empty.
- Forward chain: issue add x5 (rf_we=1, rd=5), then next cycle ID reads x5 via rs1 -> fwd_sel1=01.
  - One cycle later, a reader of x5 sees 10; two cycles later, 11; three cycles later, 00.
- Load-use: ID holds a load with rd=7, next ID uses rs2=7 -> stall_pc, stall_if_id and flush_id_ex are 1 for exactly 1 cycle, then fwd_sel2=10 with no stall.
- x0 and unused source: an older instruction writes rd=0, or the ID instruction has rs2_used=0 with rs2 equal to a pending rd -> fwd_sel stays 00 and no stall.
- Redirect priority: ex_redirect=1 in the same cycle as a load-use match -> flush_if_id=1, flush_id_ex=1, stall_pc=0. Next cycle the EX entry has v=0.
- Priority: x3 is written in EX and also in WB, ID reads rs1=3 -> fwd_sel1=01. With HAZARD_CTRL_PERF_EN, after 3 load-use events and 2 redirects the counters read 3 and 2.
